// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 (8E1/8O1 with UART_RX_PARITY_EN) serial receiver with valid/ack handoff
//   ref_clk, reset : system clock, synchronous active-high reset
//   sample_clk     : oversample tick from frac_div, edge-detected into the ref_clk domain
//   in             : serial line, idle high, LSB first
//   out, valid     : received byte and its level-valid, cleared by ack
//   ack            : consumer strobe, clears valid and overrun
//   ferr, perr     : one-cycle pulses for bad stop bit / parity mismatch (perr is 0 unless UART_RX_PARITY_EN)
//   overrun        : sticky, a byte completed while valid was still high
module uart_rx #(
    parameter int Oversample = 16,
    parameter bit ParityOdd  = 1'b0
) (
    input  logic       ref_clk,
    input  logic       reset,
    input  logic       sample_clk,
    input  logic       in,
    output logic [7:0] out,
    output logic       valid,
    input  logic       ack,
    output logic       ferr,
    output logic       perr,
    output logic       overrun
);
    localparam int CW = $clog2(Oversample);
    localparam int M  = Oversample / 2;
    localparam logic [CW-1:0] C_A = CW'(M - 1);
    localparam logic [CW-1:0] C_B = CW'(M);
    localparam logic [CW-1:0] C_D = CW'(M + 1);
    localparam logic [CW-1:0] C_W = CW'(Oversample - 1);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state, nxt;
    logic          in_s1, line, sc1, sc2, sc3, tick, dec, bit_v, v_a, v_b;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    sh;

    // synchronisers reset to 1 so a released reset never looks like a start bit or a tick
    always_ff @(posedge ref_clk) begin
        if (reset) begin
            {in_s1, line, sc1, sc2, sc3} <= '1;
        end else begin
            in_s1 <= in;
            line  <= in_s1;
            sc1   <= sample_clk;
            sc2   <= sc1;
            sc3   <= sc2;
        end
    end

    assign tick  = sc2 & ~sc3;
    assign dec   = tick && cnt == C_D;
    assign bit_v = (v_a & v_b) | (v_a & line) | (v_b & line);

    always_ff @(posedge ref_clk) begin
        if (reset) state <= WAIT_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            WAIT_IDLE: nxt = (tick && line) ? IDLE : state;
            IDLE:      nxt = (tick && !line) ? START : state;
            START:     nxt = dec ? (bit_v ? IDLE : DATA) : state;
`ifdef UART_RX_PARITY_EN
            DATA:      nxt = (dec && idx == 3'd7) ? PARITY : state;
            PARITY:    nxt = dec ? STOP : state;
`else
            DATA:      nxt = (dec && idx == 3'd7) ? STOP : state;
`endif
            STOP:      nxt = dec ? (bit_v ? IDLE : WAIT_IDLE) : state;
            default:   nxt = WAIT_IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic perr_r, pend;
    assign perr = perr_r;
`else
    assign perr = ParityOdd & 1'b0;
`endif

    // the start-detect tick is cell position 0; the counter is held at 0 while waiting for a start
    always_ff @(posedge ref_clk) begin
        if (reset) begin
            cnt     <= '0;
            idx     <= '0;
            sh      <= '0;
            v_a     <= 1'b1;
            v_b     <= 1'b1;
            out     <= '0;
            valid   <= 1'b0;
            ferr    <= 1'b0;
            overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_r  <= 1'b0;
            pend    <= 1'b0;
`endif
        end else begin
            ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_r <= 1'b0;
`endif
            if (ack && valid) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end
            if (tick) begin
                cnt <= (nxt == IDLE || nxt == WAIT_IDLE || cnt == C_W) ? '0 : cnt + CW'(1);
                if (cnt == C_A) v_a <= line;
                if (cnt == C_B) v_b <= line;
            end
            if (dec) begin
                case (state)
                    START: begin
                        idx <= '0;
`ifdef UART_RX_PARITY_EN
                        pend <= 1'b0;
`endif
                    end
                    DATA: begin
                        sh  <= {bit_v, sh[7:1]};
                        idx <= idx + 3'd1;
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: pend <= bit_v != (^sh ^ ParityOdd);
`endif
                    STOP: begin
                        if (!bit_v) begin
                            ferr <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (pend) begin
                            perr_r <= 1'b1;
`endif
                        // an ack in this same cycle frees the slot, so the new byte still loads
                        end else if (!valid || ack) begin
                            out   <= sh;
                            valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed plus randomized frames against a frame-level outcome model
module tb_uart_rx;
    logic       ref_clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_clk = 1'b0;
    logic       serin = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] out;
    logic       valid, ferr, perr, overrun;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   ferr_hi = 0;
    int   perr_hi = 0;
    int   rise_cyc = 0;
    int   t_start = 0;
    logic pv = 1'b0;

    logic [7:0] exp_out = 8'h00;
    bit         exp_valid = 1'b0;
    bit         exp_ovr = 1'b0;
    int         exp_ferr = 0;
    int         exp_perr = 0;

    localparam int OS = 16;
    localparam int TDIV = 4;
    localparam int CELL = OS * TDIV;

    uart_rx #(.Oversample(OS), .ParityOdd(1'b0)) dut (
        .ref_clk(ref_clk),
        .reset(reset),
        .sample_clk(sample_clk),
        .in(serin),
        .out(out),
        .valid(valid),
        .ack(ack),
        .ferr(ferr),
        .perr(perr),
        .overrun(overrun)
    );

    initial forever #5 ref_clk = ~ref_clk;

    always @(posedge ref_clk) cyc <= cyc + 1;

    initial forever begin
        @(negedge ref_clk);
        sample_clk = (cyc % TDIV) < 2;
    end

    always @(negedge ref_clk) begin
        if (ferr) ferr_hi <= ferr_hi + 1;
        if (perr) perr_hi <= perr_hi + 1;
        if (valid && !pv) rise_cyc <= cyc;
        pv <= valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic cells(input int n);
        repeat (CELL * n) @(negedge ref_clk);
    endtask

    // start bits are launched on the negedge where sample_clk rises, making tick timing exact
    task automatic align();
        do @(negedge ref_clk); while (cyc % TDIV != 0);
    endtask

    task automatic send(input logic [7:0] d, input bit stop, input bit hp, input bit pb);
        t_start = cyc;
        serin = 1'b0;
        cells(1);
        for (int i = 0; i < 8; i++) begin
            serin = d[i];
            cells(1);
        end
        if (hp) begin
            serin = pb;
            cells(1);
        end
        serin = stop;
        cells(1);
        serin = 1'b1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_valid"}, 32'(valid), 32'(exp_valid));
        chk({tag, "_ovr"}, 32'(overrun), 32'(exp_ovr));
        chk({tag, "_ferr"}, ferr_hi, exp_ferr);
        chk({tag, "_perr"}, perr_hi, exp_perr);
        if (exp_valid) chk({tag, "_out"}, 32'(out), 32'(exp_out));
    endtask

    // frame outcome from the receive rules; start edge to valid = (9+p)*OS + OS/2 + 1 ticks + 3 cycles
    task automatic frame(input string tag, input logic [7:0] d, input bit stop, input bit hp, input bit pb);
        bit par_ok;
        bit loaded;
        int lat;
        par_ok = !hp || (($countones(d) + int'(pb)) % 2 == 0);
        lat = ((9 + int'(hp)) * OS + OS / 2 + 1) * TDIV + 3;
        loaded = 1'b0;
        align();
        send(d, stop, hp, pb);
        cells(1);
        if (!stop) exp_ferr++;
        else if (!par_ok) exp_perr++;
        else if (exp_valid) exp_ovr = 1'b1;
        else begin
            exp_valid = 1'b1;
            exp_out = d;
            loaded = 1'b1;
        end
        if (loaded) chk({tag, "_lat"}, rise_cyc - t_start, lat);
        check_state(tag);
    endtask

    task automatic do_ack();
        @(negedge ref_clk);
        ack = 1'b1;
        @(negedge ref_clk);
        ack = 1'b0;
        if (exp_valid) begin
            exp_valid = 1'b0;
            exp_ovr = 1'b0;
        end
    endtask

    initial begin
        repeat (6) @(negedge ref_clk);
        chk("rst_out", 32'(out), 32'h0);
        check_state("rst");
        reset = 1'b0;
        cells(1);

        frame("f14", 8'h14, 1'b1, 1'b0, 1'b0);
        do_ack();
        check_state("ack14");

        align();
        serin = 1'b0;
        repeat (5 * TDIV) @(negedge ref_clk);
        serin = 1'b1;
        cells(2);
        check_state("false_start");
        frame("fA5", 8'hA5, 1'b1, 1'b0, 1'b0);
        do_ack();

        frame("f3C", 8'h3C, 1'b0, 1'b0, 1'b0);
        frame("f55", 8'h55, 1'b1, 1'b0, 1'b0);
        do_ack();

        frame("f01", 8'h01, 1'b1, 1'b0, 1'b0);
        frame("f02", 8'h02, 1'b1, 1'b0, 1'b0);
        do_ack();
        check_state("ack_ovr");

        frame("g01", 8'h01, 1'b1, 1'b0, 1'b0);
        align();
        fork
            send(8'h02, 1'b1, 1'b0, 1'b0);
            begin
                repeat ((9 * OS + OS / 2 + 1) * TDIV + 2) @(negedge ref_clk);
                ack = 1'b1;
                @(negedge ref_clk);
                ack = 1'b0;
            end
        join
        cells(1);
        exp_out = 8'h02;
        exp_valid = 1'b1;
        exp_ovr = 1'b0;
        check_state("coincide");

        frame("f03", 8'h03, 1'b1, 1'b0, 1'b0);
        align();
        serin = 1'b0;
        cells(1);
        serin = 1'b1;
        cells(3);
        repeat (CELL / 2) @(negedge ref_clk);
        reset = 1'b1;
        repeat (3) @(negedge ref_clk);
        exp_valid = 1'b0;
        exp_ovr = 1'b0;
        chk("mid_rst_out", 32'(out), 32'h0);
        chk("mid_rst_ferr", 32'(ferr), 32'h0);
        chk("mid_rst_perr", 32'(perr), 32'h0);
        check_state("mid_rst");
        serin = 1'b0;
        repeat (8) @(negedge ref_clk);
        reset = 1'b0;
        cells(2);
        serin = 1'b1;
        cells(2);
        check_state("post_rst");
        frame("f81", 8'h81, 1'b1, 1'b0, 1'b0);
        do_ack();

        for (int n = 0; n < 20; n++) begin
            logic [7:0] d;
            d = 8'($urandom);
            frame("rnd", d, ($urandom % 5) != 0, 1'b0, 1'b0);
            if ($urandom % 2) do_ack();
            cells($urandom_range(0, 2));
        end

`ifdef UART_RX_PARITY_EN
        do_ack();
        frame("p07ok", 8'h07, 1'b1, 1'b1, 1'b1);
        do_ack();
        frame("p07bad", 8'h07, 1'b1, 1'b1, 1'b0);
        for (int n = 0; n < 6; n++) begin
            do_ack();
            frame("prnd", 8'($urandom), 1'b1, 1'b1, 1'($urandom));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
